// File: rtl/wb_port_arbiter.sv
// Register file write-port arbiter: pipeline results take priority.
// Mul/div results are queued and tracked by a pending-destination scoreboard.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PIPE_VALID,
  input  logic [AW-1:0] PIPE_ADDR,
  input  logic [DW-1:0] PIPE_DATA,
  input  logic          MD_VALID,
  input  logic [AW-1:0] MD_ADDR,
  input  logic [DW-1:0] MD_DATA,
  output logic          MD_READY,
  input  logic          MD_ISSUE,
  input  logic [AW-1:0] MD_ISSUE_ADDR,
  output logic          WB_WRITE,
  output logic [AW-1:0] WB_ADDR,
  output logic [DW-1:0] WB_DATA,
  output logic [31:0]   PENDING,
  output logic [CW-1:0] FIFO_COUNT
);

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          wb_write_q, wb_write_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [31:0]   pending_q, pending_d;

  logic          pipe_hit;
  logic          fifo_empty;
  logic          fifo_full;
  logic          md_ready;
  logic          md_xfer;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [31:0]   set_vec;
  logic [31:0]   clr_vec;

  // Handshake and arbitration decisions for this edge
  always_comb begin
    pipe_hit   = PIPE_VALID && (PIPE_ADDR != '0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    md_ready   = !RESET && !fifo_full;
    md_xfer    = MD_VALID && md_ready;
    push       = md_xfer && (MD_ADDR != '0);
    pop        = !pipe_hit && !fifo_empty;
    head_addr  = addr_mem_q[rd_ptr_q];
    head_data  = data_mem_q[rd_ptr_q];
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write-port selection: pipeline first, else FIFO head, else hold
  always_comb begin
    wb_write_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (pipe_hit) begin
      wb_write_d = 1'b1;
      wb_addr_d  = PIPE_ADDR;
      wb_data_d  = PIPE_DATA;
    end else if (pop) begin
      wb_write_d = 1'b1;
      wb_addr_d  = head_addr;
      wb_data_d  = head_data;
    end
  end

  // Scoreboard: issue sets, FIFO retire clears, set wins on collision
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (MD_ISSUE && (MD_ISSUE_ADDR != '0)) begin
      set_vec = 32'd1 << MD_ISSUE_ADDR;
    end
    if (pop) begin
      clr_vec = 32'd1 << head_addr;
    end
    pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  // FIFO storage; contents are don't-care while count says empty
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= MD_ADDR;
      data_mem_q[wr_ptr_q] <= MD_DATA;
    end
  end

  // Control state with asynchronous clear; reset drops queued results
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wb_write_q <= wb_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      pending_q  <= pending_d;
    end
  end

  assign MD_READY   = md_ready;
  assign WB_WRITE   = wb_write_q;
  assign WB_ADDR    = wb_addr_q;
  assign WB_DATA    = wb_data_q;
  assign PENDING    = pending_q;
  assign FIFO_COUNT = count_q;

endmodule
